// File: rtl/cpu6502_core_bus.sv
// 6502-subset core with a registered read/write bus and mem_ready wait states.
// Supports NOP/INX/DEX/TAX, LDA/LDX/LDY #imm, BNE, JMP abs and STA abs; other opcodes halt.
module cpu6502_core_bus #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [7:0]  P_RESET      = 8'h34
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rd_data,
  input  logic        mem_ready,
  output logic [15:0] address,
  output logic        rd_en,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic        sync,
  output logic        halted,
  output logic [15:0] dbg_pc,
  output logic [7:0]  dbg_a,
  output logic [7:0]  dbg_x,
  output logic [7:0]  dbg_y,
  output logic [7:0]  dbg_p
);

  localparam logic [8:0] S_RESET  = 9'b000000001;
  localparam logic [8:0] S_VEC_LO = 9'b000000010;
  localparam logic [8:0] S_VEC_HI = 9'b000000100;
  localparam logic [8:0] S_FETCH  = 9'b000001000;
  localparam logic [8:0] S_OPER1  = 9'b000010000;
  localparam logic [8:0] S_OPER2  = 9'b000100000;
  localparam logic [8:0] S_WRITE  = 9'b001000000;
  localparam logic [8:0] S_EXEC   = 9'b010000000;
  localparam logic [8:0] S_HALT   = 9'b100000000;

  localparam logic [7:0] OP_NOP = 8'hEA;
  localparam logic [7:0] OP_INX = 8'hE8;
  localparam logic [7:0] OP_DEX = 8'hCA;
  localparam logic [7:0] OP_TAX = 8'hAA;
  localparam logic [7:0] OP_LDA = 8'hA9;
  localparam logic [7:0] OP_LDX = 8'hA2;
  localparam logic [7:0] OP_LDY = 8'hA0;
  localparam logic [7:0] OP_BNE = 8'hD0;
  localparam logic [7:0] OP_JMP = 8'h4C;
  localparam logic [7:0] OP_STA = 8'h8D;

  logic [8:0]  state;
  logic [15:0] pc;
  logic [7:0]  ir, a, x, y, p, lo;

  logic [15:0] pc_inc;
  logic [15:0] branch_target;
  logic [7:0]  x_inc, x_dec;

  assign pc_inc        = pc + 16'd1;
  assign branch_target = pc_inc + {{8{rd_data[7]}}, rd_data};
  assign x_inc         = x + 8'd1;
  assign x_dec         = x - 8'd1;

  // Only N (bit 7) and Z (bit 1) are produced by this core; other bits pass through.
  function automatic logic [7:0] set_nz(input logic [7:0] p_in, input logic [7:0] r);
    set_nz = {r[7], p_in[6:2], (r == 8'h00), p_in[0]};
  endfunction

  // NOTE: all architectural and bus state is updated with non-blocking assignments so
  // every branch below reads the pre-edge values of pc, p and the registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: reset is synchronous; every register, including IR and the operand latch,
      // gets a defined value so an aborted access leaves nothing behind.
      state   <= S_RESET;
      address <= 16'h0000;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      wr_data <= 8'h00;
      sync    <= 1'b0;
      halted  <= 1'b0;
      pc      <= 16'h0000;
      a       <= 8'h00;
      x       <= 8'h00;
      y       <= 8'h00;
      p       <= P_RESET;
      ir      <= OP_NOP;
      lo      <= 8'h00;
    end else begin
      case (state)
        S_RESET: begin
          state   <= S_VEC_LO;
          address <= RESET_VECTOR;
          rd_en   <= 1'b1;
        end
        S_VEC_LO: if (mem_ready) begin
          pc[7:0] <= rd_data;
          state   <= S_VEC_HI;
          address <= RESET_VECTOR + 16'd1;
        end
        S_VEC_HI: if (mem_ready) begin
          pc[15:8] <= rd_data;
          state    <= S_FETCH;
          address  <= {rd_data, pc[7:0]};
          sync     <= 1'b1;
        end
        S_FETCH: if (mem_ready) begin
          ir   <= rd_data;
          pc   <= pc_inc;
          sync <= 1'b0;
          case (rd_data)
            OP_NOP, OP_INX, OP_DEX, OP_TAX: begin
              state <= S_EXEC;
              rd_en <= 1'b0;
            end
            OP_LDA, OP_LDX, OP_LDY, OP_BNE, OP_JMP, OP_STA: begin
              state   <= S_OPER1;
              address <= pc_inc;
            end
            default: begin
              state  <= S_HALT;
              rd_en  <= 1'b0;
              halted <= 1'b1;
            end
          endcase
        end
        S_EXEC: begin
          case (ir)
            OP_INX: begin x <= x_inc; p <= set_nz(p, x_inc); end
            OP_DEX: begin x <= x_dec; p <= set_nz(p, x_dec); end
            OP_TAX: begin x <= a;     p <= set_nz(p, a);     end
            default: ;
          endcase
          state   <= S_FETCH;
          address <= pc;
          rd_en   <= 1'b1;
          sync    <= 1'b1;
        end
        S_OPER1: if (mem_ready) begin
          lo      <= rd_data;
          pc      <= pc_inc;
          address <= pc_inc;
          state   <= S_FETCH;
          sync    <= 1'b1;
          case (ir)
            OP_LDA: begin a <= rd_data; p <= set_nz(p, rd_data); end
            OP_LDX: begin x <= rd_data; p <= set_nz(p, rd_data); end
            OP_LDY: begin y <= rd_data; p <= set_nz(p, rd_data); end
            OP_BNE: if (!p[1]) begin
              pc      <= branch_target;
              address <= branch_target;
            end
            default: begin
              state <= S_OPER2;
              sync  <= 1'b0;
            end
          endcase
        end
        S_OPER2: if (mem_ready) begin
          if (ir == OP_JMP) begin
            pc      <= {rd_data, lo};
            address <= {rd_data, lo};
            state   <= S_FETCH;
            sync    <= 1'b1;
          end else begin
            pc      <= pc_inc;
            address <= {rd_data, lo};
            rd_en   <= 1'b0;
            wr_en   <= 1'b1;
            wr_data <= a;
            state   <= S_WRITE;
          end
        end
        S_WRITE: if (mem_ready) begin
          wr_en   <= 1'b0;
          rd_en   <= 1'b1;
          sync    <= 1'b1;
          address <= pc;
          state   <= S_FETCH;
        end
        S_HALT: ;
        default: begin
          state  <= S_HALT;
          rd_en  <= 1'b0;
          wr_en  <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_pc = pc;
  assign dbg_a  = a;
  assign dbg_x  = x;
  assign dbg_y  = y;
  assign dbg_p  = p;

endmodule

// File: tb/tb_cpu6502_core_bus.sv
// Self-checking bench: memory responder with wait states, ISA-level reference model,
// table of short programs, directed corner cases and random straight-line programs.
module tb_cpu6502_core_bus;
  localparam logic [15:0] RV = 16'hFFFC;
  localparam logic [7:0]  PR = 8'h34;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        mem_ready = 1'b0;
  logic [15:0] address;
  logic        rd_en, wr_en, sync, halted;
  logic [7:0]  wr_data;
  logic [15:0] dbg_pc;
  logic [7:0]  dbg_a, dbg_x, dbg_y, dbg_p;

  cpu6502_core_bus #(.RESET_VECTOR(RV), .P_RESET(PR)) dut (
    .clk(clk), .resetn(resetn), .rd_data(rd_data), .mem_ready(mem_ready),
    .address(address), .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data),
    .sync(sync), .halted(halted), .dbg_pc(dbg_pc), .dbg_a(dbg_a),
    .dbg_x(dbg_x), .dbg_y(dbg_y), .dbg_p(dbg_p)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
    logic        sync;
  } acc_t;

  typedef struct packed {
    logic [63:0] prog;
    logic [3:0]  len;
    logic [7:0]  a, x, y, p;
    logic [7:0]  cycles;
  } vec_t;

  logic [7:0] mem [0:65535];
  acc_t log_q[$];
  int   log_cyc[$];
  acc_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   cyc = 0, mode = 0, wait_n = 0, wcnt = 0;
  int   wr_cycles = 0, acc_cycles = 0, halt_cyc = -1;
  bit   pend = 0;
  acc_t prev, cur;

  logic [7:0]  m_a, m_x, m_y, m_p;
  logic [15:0] m_pc;
  bit          m_halt;
  int          m_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Memory responder and bus monitor; everything is evaluated on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (halted && halt_cyc < 0) halt_cyc = cyc;
    if (rd_en || wr_en) begin
      cur.addr = address;
      cur.wr   = wr_en;
      cur.data = wr_en ? wr_data : 8'h00;
      cur.sync = sync;
      acc_cycles++;
      if (wr_en) wr_cycles++;
      check("rd_wr_overlap", {31'b0, rd_en & wr_en}, 32'd0);
      if (pend) check("access_stable", cur, prev);
      case (mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = (wcnt >= wait_n);
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      rd_data = mem[address];
      if (mem_ready) begin
        log_q.push_back(cur);
        log_cyc.push_back(cyc);
        if (wr_en) mem[address] = wr_data;
        wcnt = 0;
        pend = 0;
      end else begin
        wcnt++;
        pend = 1;
        prev = cur;
      end
    end else begin
      pend = 0;
      wcnt = 0;
      mem_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rd_data = 8'($urandom);
    end
  end

  function automatic logic [7:0] nz(input logic [7:0] pv, input logic [7:0] r);
    nz = (pv & 8'h7D) | (r & 8'h80) | ((r == 8'h00) ? 8'h02 : 8'h00);
  endfunction

  function automatic acc_t mk(input logic [15:0] ad, input logic w, input logic [7:0] d, input logic s);
    mk.addr = ad; mk.wr = w; mk.data = d; mk.sync = s;
  endfunction

  // Instruction-level interpreter producing the expected completed-access stream.
  task automatic model_run(input int max_acc);
    logic [15:0] pc;
    logic [7:0]  op, b1, b2;
    exp_q.delete();
    m_cycles = 0;
    m_halt = 0;
    exp_q.push_back(mk(RV, 1'b0, 8'h00, 1'b0));
    exp_q.push_back(mk(RV + 16'd1, 1'b0, 8'h00, 1'b0));
    pc = {mem[RV + 16'd1], mem[RV]};
    m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_p = PR;
    while (exp_q.size() < max_acc && !m_halt) begin
      op = mem[pc];
      exp_q.push_back(mk(pc, 1'b0, 8'h00, 1'b1));
      pc = pc + 16'd1;
      case (op)
        8'hEA: m_cycles += 2;
        8'hE8: begin m_x = m_x + 8'd1; m_p = nz(m_p, m_x); m_cycles += 2; end
        8'hCA: begin m_x = m_x - 8'd1; m_p = nz(m_p, m_x); m_cycles += 2; end
        8'hAA: begin m_x = m_a;        m_p = nz(m_p, m_x); m_cycles += 2; end
        8'hA9, 8'hA2, 8'hA0, 8'hD0: begin
          b1 = mem[pc];
          exp_q.push_back(mk(pc, 1'b0, 8'h00, 1'b0));
          pc = pc + 16'd1;
          m_cycles += 2;
          if (op == 8'hA9) begin m_a = b1; m_p = nz(m_p, b1); end
          if (op == 8'hA2) begin m_x = b1; m_p = nz(m_p, b1); end
          if (op == 8'hA0) begin m_y = b1; m_p = nz(m_p, b1); end
          if (op == 8'hD0 && m_p[1] == 1'b0)
            pc = pc + 16'(b1) - ((b1 >= 8'd128) ? 16'd256 : 16'd0);
        end
        8'h4C, 8'h8D: begin
          b1 = mem[pc];
          exp_q.push_back(mk(pc, 1'b0, 8'h00, 1'b0));
          b2 = mem[pc + 16'd1];
          exp_q.push_back(mk(pc + 16'd1, 1'b0, 8'h00, 1'b0));
          if (op == 8'h4C) begin
            pc = {b2, b1};
            m_cycles += 3;
          end else begin
            pc = pc + 16'd2;
            exp_q.push_back(mk({b2, b1}, 1'b1, m_a, 1'b0));
            m_cycles += 4;
          end
        end
        default: m_halt = 1;
      endcase
    end
    m_pc = pc;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[RV] = 8'h00;
    mem[RV + 16'd1] = 8'h80;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    log_q.delete();
    log_cyc.delete();
    halt_cyc = -1;
    wr_cycles = 0;
    pend = 0;
    wcnt = 0;
    resetn = 1'b1;
  endtask

  task automatic run_prog(input string tag, input int md, input int wn, input int max_acc);
    int budget;
    mode = md;
    wait_n = wn;
    model_run(max_acc);
    do_reset();
    budget = 0;
    while ((log_q.size() < exp_q.size() || (m_halt && !halted)) && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    check({tag, " finished"}, 32'(budget < 20000), 32'd1);
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s access%0d", tag, i), log_q[i], exp_q[i]);
    if (m_halt) begin
      check({tag, " access_count"}, log_q.size(), exp_q.size());
      check({tag, " halted"}, {31'b0, halted}, 32'd1);
      check({tag, " a"}, dbg_a, m_a);
      check({tag, " x"}, dbg_x, m_x);
      check({tag, " y"}, dbg_y, m_y);
      check({tag, " p"}, dbg_p, m_p);
      check({tag, " pc"}, dbg_pc, m_pc);
      if (md != 2 && log_cyc.size() == exp_q.size())
        check({tag, " cycles"}, log_cyc[log_cyc.size() - 1] - log_cyc[2],
              m_cycles + ((md == 1) ? wn * (exp_q.size() - 3) : 0));
    end
  endtask

  task automatic put(inout logic [15:0] ad, input logic [7:0] b);
    mem[ad] = b;
    ad = ad + 16'd1;
  endtask

  task automatic gen_prog(input int n);
    logic [15:0] ad, t;
    logic [7:0]  imm;
    int sel;
    ad = 16'h8000;
    for (int k = 0; k < n; k++) begin
      imm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0: put(ad, 8'hEA);
        1: put(ad, 8'hE8);
        2: put(ad, 8'hCA);
        3: put(ad, 8'hAA);
        4: begin put(ad, 8'hA9); put(ad, imm); end
        5: begin put(ad, 8'hA2); put(ad, imm); end
        6: begin put(ad, 8'hA0); put(ad, imm); end
        7: begin put(ad, 8'h8D); put(ad, 8'($urandom)); put(ad, 8'h02); end
        8: begin put(ad, 8'hD0); put(ad, 8'h02); put(ad, 8'hA9); put(ad, imm); end
        default: begin
          t = ad + 16'd3;
          put(ad, 8'h4C); put(ad, t[7:0]); put(ad, t[15:8]);
        end
      endcase
    end
    put(ad, 8'h02);
  endtask

  vec_t tbl [8];
  vec_t tv;
  int   n_wr, a0, budget;
  logic [15:0] exp_addr [6];
  logic        exp_sync [6];

  initial begin
    tbl[0] = '{64'hA2FF_E800_0000_0000, 4'd3, 8'h00, 8'h00, 8'h00, 8'h36, 8'd4};
    tbl[1] = '{64'hA2FF_E8CA_0000_0000, 4'd4, 8'h00, 8'hFF, 8'h00, 8'hB4, 8'd6};
    tbl[2] = '{64'hA900_AA00_0000_0000, 4'd3, 8'h00, 8'h00, 8'h00, 8'h36, 8'd4};
    tbl[3] = '{64'hA980_EA00_0000_0000, 4'd3, 8'h80, 8'h00, 8'h00, 8'hB4, 8'd4};
    tbl[4] = '{64'hA001_D002_A955_A207, 4'd8, 8'h00, 8'h07, 8'h01, 8'h34, 8'd6};
    tbl[5] = '{64'hA900_D002_A080_0000, 4'd6, 8'h00, 8'h00, 8'h80, 8'hB4, 8'd6};
    tbl[6] = '{64'hA97F_8D00_0200_0000, 4'd5, 8'h7F, 8'h00, 8'h00, 8'h34, 8'd6};
    tbl[7] = '{64'h4C05_80EA_EAA2_0000, 4'd7, 8'h00, 8'h00, 8'h00, 8'h36, 8'd5};

    clear_mem();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset address", address, 32'h0);
    check("reset rd_en", {31'b0, rd_en}, 32'd0);
    check("reset wr_en", {31'b0, wr_en}, 32'd0);
    check("reset sync", {31'b0, sync}, 32'd0);
    check("reset halted", {31'b0, halted}, 32'd0);
    check("reset pc", dbg_pc, 32'h0);
    check("reset p", dbg_p, PR);
    check("reset a", dbg_a, 32'h0);

    // Test plan 1: reset vector and JMP.
    clear_mem();
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    mem[16'h1234] = 8'h02;
    run_prog("jmp", 0, 0, 1000);
    exp_addr = '{16'hFFFC, 16'hFFFD, 16'h8000, 16'h8001, 16'h8002, 16'h1234};
    exp_sync = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      check($sformatf("jmp addr%0d", i), log_q[i].addr, exp_addr[i]);
      check($sformatf("jmp sync%0d", i), {31'b0, log_q[i].sync}, {31'b0, exp_sync[i]});
    end

    // Table of short programs with hand-derived results.
    for (int v = 0; v < 8; v++) begin
      tv = tbl[v];
      clear_mem();
      for (int i = 0; i < int'(tv.len); i++) mem[16'h8000 + 16'(i)] = tv.prog[63 - 8 * i -: 8];
      mem[16'h8000 + 16'(tv.len)] = 8'h02;
      run_prog($sformatf("vec%0d", v), 0, 0, 1000);
      check($sformatf("vec%0d tbl_a", v), dbg_a, tv.a);
      check($sformatf("vec%0d tbl_x", v), dbg_x, tv.x);
      check($sformatf("vec%0d tbl_y", v), dbg_y, tv.y);
      check($sformatf("vec%0d tbl_p", v), dbg_p, tv.p);
      if (log_cyc.size() >= 3)
        check($sformatf("vec%0d tbl_cycles", v), log_cyc[log_cyc.size() - 1] - log_cyc[2], tv.cycles);
      if (v == 6) check("vec6 stored", mem[16'h0200], 8'h7F);
    end

    // Test plan 2: LDA/STA with two wait cycles per access.
    clear_mem();
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h80;
    mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h02;
    mem[16'h8005] = 8'h02;
    run_prog("sta_wait", 1, 2, 1000);
    n_wr = 0;
    foreach (log_q[i]) if (log_q[i].wr) begin
      n_wr++;
      check("sta_wait wr_addr", log_q[i].addr, 32'h0200);
      check("sta_wait wr_data", log_q[i].data, 32'h80);
    end
    check("sta_wait n_writes", n_wr, 32'd1);
    check("sta_wait wr_cycles", wr_cycles, 32'd3);
    check("sta_wait a", dbg_a, 32'h80);
    check("sta_wait n", {31'b0, dbg_p[7]}, 32'd1);
    check("sta_wait z", {31'b0, dbg_p[1]}, 32'd0);

    // Test plan 4: BNE taken backwards across a page, then not taken.
    clear_mem();
    mem[RV] = 8'hFE; mem[RV + 16'd1] = 8'h8F;
    mem[16'h8FFE] = 8'hA0; mem[16'h8FFF] = 8'h01;
    mem[16'h9000] = 8'hD0; mem[16'h9001] = 8'hFC;
    run_prog("bne_taken", 0, 0, 10);
    if (log_q.size() > 6) check("bne_taken target", log_q[6].addr, 32'h8FFE);
    mem[16'h8FFE] = 8'hA9; mem[16'h8FFF] = 8'h00;
    mem[16'h9002] = 8'h02;
    run_prog("bne_not", 0, 0, 1000);
    if (log_q.size() > 6) check("bne_not target", log_q[6].addr, 32'h9002);

    // Test plan 5: illegal opcode halts until reset.
    clear_mem();
    mem[16'h8000] = 8'h02;
    run_prog("illegal", 0, 0, 1000);
    if (log_cyc.size() > 2) check("illegal halt_timing", halt_cyc, log_cyc[2] + 1);
    a0 = acc_cycles;
    repeat (20) @(negedge clk);
    check("illegal no_access", acc_cycles - a0, 32'd0);
    check("illegal still_halted", {31'b0, halted}, 32'd1);
    do_reset();
    check("illegal reset_clears", {31'b0, halted}, 32'd0);
    budget = 0;
    while (log_q.size() < 2 && budget < 100) begin @(negedge clk); budget++; end
    check("illegal revector_done", 32'(log_q.size() >= 2), 32'd1);
    if (log_q.size() >= 2) begin
      check("illegal revector_lo", log_q[0].addr, 32'hFFFC);
      check("illegal revector_hi", log_q[1].addr, 32'hFFFD);
    end

    // Test plan 6: reset asserted while the STA write is waiting.
    clear_mem();
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h80;
    mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h02;
    mode = 1; wait_n = 2;
    do_reset();
    budget = 0;
    while (!wr_en && budget < 200) begin @(negedge clk); budget++; end
    check("rst_write reached", {31'b0, wr_en}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_write address", address, 32'h0);
    check("rst_write rd_en", {31'b0, rd_en}, 32'd0);
    check("rst_write wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_write wr_data", wr_data, 32'h0);
    check("rst_write sync", {31'b0, sync}, 32'd0);
    check("rst_write a", dbg_a, 32'h0);
    check("rst_write pc", dbg_pc, 32'h0);
    check("rst_write p", dbg_p, PR);
    check("rst_write mem", mem[16'h0200], 32'h0);
    log_q.delete(); log_cyc.delete();
    resetn = 1'b1;
    budget = 0;
    while (log_q.size() < 3 && budget < 200) begin @(negedge clk); budget++; end
    check("rst_write restart_done", 32'(log_q.size() >= 3), 32'd1);
    if (log_q.size() >= 3) begin
      check("rst_write vec_lo", log_q[0].addr, 32'hFFFC);
      check("rst_write vec_hi", log_q[1].addr, 32'hFFFD);
      check("rst_write fetch", {log_q[2].addr, 15'b0, log_q[2].sync}, {16'h8000, 16'h0001});
    end

    // Random straight-line programs under all responder modes.
    for (int r = 0; r < 6; r++) begin
      clear_mem();
      gen_prog(40);
      run_prog($sformatf("rand%0d", r), r % 3, 1, 100000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
